// File: rtl/hazard_pkg.sv
// Shared definitions for the multi-cycle hazard unit: FSM states, address defaults
// and a small constant helper used for sizing the stall down-counter.
package hazard_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int X0_ADDR    = 0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        LONG_BUSY = 2'd2
    } hz_state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Pipeline-to-hazard-unit bundle: ID/EX and IF/ID hazard inputs plus the
// enable/bubble/flush controls returned to the pipeline registers.
interface hazard_unit_mc_if import hazard_pkg::*; #(
    parameter int REG_AW = REG_AW_DEF
) ();

    logic              MemRead_IDEX;
    logic              RegWrite_IDEX;
    logic              long_op_IDEX;
    logic [REG_AW-1:0] rd_IDEX;
    logic [REG_AW-1:0] rs1_IFID;
    logic [REG_AW-1:0] rs2_IFID;
    logic              rs1_used_IFID;
    logic              rs2_used_IFID;
    logic              branch_taken_EX;
    logic              PCWrite;
    logic              IFIDWrite;
    logic              IDEXWrite;
    logic              control_mux;
    logic              flush_IFID;
    logic              exmem_bubble;

    modport master (
        output MemRead_IDEX, RegWrite_IDEX, long_op_IDEX, rd_IDEX,
        output rs1_IFID, rs2_IFID, rs1_used_IFID, rs2_used_IFID, branch_taken_EX,
        input  PCWrite, IFIDWrite, IDEXWrite, control_mux, flush_IFID, exmem_bubble
    );

    modport slave (
        input  MemRead_IDEX, RegWrite_IDEX, long_op_IDEX, rd_IDEX,
        input  rs1_IFID, rs2_IFID, rs1_used_IFID, rs2_used_IFID, branch_taken_EX,
        output PCWrite, IFIDWrite, IDEXWrite, control_mux, flush_IFID, exmem_bubble
    );

endinterface

// File: rtl/hazard_stall_counter.sv
// Loadable down-counter shared by the load-wait and long-op stall phases;
// "last" marks the final stalled cycle of the current phase.
module hazard_stall_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // next count: a load wins over a decrement, and zero never underflows
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != {CNT_W{1'b0}})) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/hazard_unit_mc.sv
// Stateful ID-stage hazard unit: multi-cycle load-use stalls, long EX ops that
// freeze the front end, taken-branch flush and a saturating stall counter.
module hazard_unit_mc import hazard_pkg::*; #(
    parameter int REG_AW     = REG_AW_DEF,
    parameter int LOAD_STALL = 1,
    parameter int LONG_LAT   = 4,
    parameter int STAT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    hazard_unit_mc_if.slave   hz,
    output logic [STAT_W-1:0] stall_count
);

    localparam int                CNT_W     = $clog2(max2(LOAD_STALL, LONG_LAT)) + 1;
    localparam logic [CNT_W-1:0]  LOAD_INIT = CNT_W'(LOAD_STALL - 1);
    localparam logic [CNT_W-1:0]  LONG_INIT = CNT_W'(LONG_LAT - 1);
    localparam logic [REG_AW-1:0] X0        = REG_AW'(X0_ADDR);

    hz_state_e          state_d, state_q;
    logic [STAT_W-1:0]  stall_count_d, stall_count_q;
    logic [REG_AW-1:0]  rd_s;
    logic               lu_s;
    logic               cnt_load_s, cnt_dec_s, cnt_last_s;
    logic [CNT_W-1:0]   cnt_val_s;
    logic               pc_write_s, ifid_write_s, idex_write_s;
    logic               control_mux_s, flush_s, exmem_bubble_s;

    assign rd_s = hz.rd_IDEX;

    // load-use compare against both decoded sources; x0 never creates a dependency
    always_comb begin
        lu_s = 1'b0;
        if (hz.MemRead_IDEX && hz.RegWrite_IDEX && (rd_s != X0)) begin
            lu_s = (hz.rs1_used_IFID && (rd_s == hz.rs1_IFID)) ||
                   (hz.rs2_used_IFID && (rd_s == hz.rs2_IFID));
        end else begin
            lu_s = 1'b0;
        end
    end

    // next-state and pipeline controls, highest-priority condition first
    always_comb begin
        state_d        = state_q;
        cnt_load_s     = 1'b0;
        cnt_val_s      = {CNT_W{1'b0}};
        cnt_dec_s      = 1'b0;
        pc_write_s     = 1'b1;
        ifid_write_s   = 1'b1;
        idex_write_s   = 1'b1;
        control_mux_s  = 1'b0;
        flush_s        = 1'b0;
        exmem_bubble_s = 1'b0;
        if (rst) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                LONG_BUSY: begin
                    // EX still owns the long op, so a redirect cannot originate there
                    pc_write_s     = 1'b0;
                    ifid_write_s   = 1'b0;
                    idex_write_s   = 1'b0;
                    exmem_bubble_s = 1'b1;
                    cnt_dec_s      = 1'b1;
                    state_d        = cnt_last_s ? IDLE : LONG_BUSY;
                end
                IDLE, LOAD_WAIT: begin
                    if (hz.branch_taken_EX) begin
                        flush_s       = 1'b1;
                        control_mux_s = 1'b1;
                        cnt_load_s    = 1'b1;
                        cnt_val_s     = {CNT_W{1'b0}};
                        state_d       = IDLE;
                    end else if (state_q == LOAD_WAIT) begin
                        pc_write_s    = 1'b0;
                        ifid_write_s  = 1'b0;
                        control_mux_s = 1'b1;
                        cnt_dec_s     = 1'b1;
                        state_d       = cnt_last_s ? IDLE : LOAD_WAIT;
                    end else if (lu_s) begin
                        pc_write_s    = 1'b0;
                        ifid_write_s  = 1'b0;
                        control_mux_s = 1'b1;
                        if (LOAD_STALL > 1) begin
                            cnt_load_s = 1'b1;
                            cnt_val_s  = LOAD_INIT;
                            state_d    = LOAD_WAIT;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (hz.long_op_IDEX) begin
                        cnt_load_s = 1'b1;
                        cnt_val_s  = LONG_INIT;
                        state_d    = LONG_BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // saturating count of cycles with the PC frozen
    always_comb begin
        stall_count_d = stall_count_q;
        if (!pc_write_s && (stall_count_q != {STAT_W{1'b1}})) begin
            stall_count_d = stall_count_q + STAT_W'(1);
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // FSM and statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            stall_count_q <= {STAT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
        end
    end

    hazard_stall_counter #(
        .CNT_W (CNT_W)
    ) u_stall_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_s),
        .load_val (cnt_val_s),
        .dec      (cnt_dec_s),
        .last     (cnt_last_s)
    );

    assign hz.PCWrite      = pc_write_s;
    assign hz.IFIDWrite    = ifid_write_s;
    assign hz.IDEXWrite    = idex_write_s;
    assign hz.control_mux  = control_mux_s;
    assign hz.flush_IFID   = flush_s;
    assign hz.exmem_bubble = exmem_bubble_s;
    assign stall_count     = stall_count_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Drives two hazard units (LOAD_STALL=1/STAT_W=16 and LOAD_STALL=3/STAT_W=4) with
// the same stimulus and compares both against a remaining-cycles reference model.
module tb_hazard_unit_mc;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_read, reg_write, long_op, br;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2;
    logic [15:0] sc_a;
    logic [3:0]  sc_b;

    int n_checks = 0;
    int n_fail   = 0;

    int ls[2]  = '{1, 3};
    int cap[2] = '{65535, 15};
    localparam int LL = 4;
    int m_load[2] = '{0, 0};
    int m_long[2] = '{0, 0};
    int m_cnt[2]  = '{0, 0};

    always #5 clk = ~clk;

    hazard_unit_mc_if #(.REG_AW(5)) if_a ();
    hazard_unit_mc_if #(.REG_AW(5)) if_b ();

    assign if_a.MemRead_IDEX = mem_read;   assign if_b.MemRead_IDEX = mem_read;
    assign if_a.RegWrite_IDEX = reg_write; assign if_b.RegWrite_IDEX = reg_write;
    assign if_a.long_op_IDEX = long_op;    assign if_b.long_op_IDEX = long_op;
    assign if_a.rd_IDEX = rd;              assign if_b.rd_IDEX = rd;
    assign if_a.rs1_IFID = rs1;            assign if_b.rs1_IFID = rs1;
    assign if_a.rs2_IFID = rs2;            assign if_b.rs2_IFID = rs2;
    assign if_a.rs1_used_IFID = u1;        assign if_b.rs1_used_IFID = u1;
    assign if_a.rs2_used_IFID = u2;        assign if_b.rs2_used_IFID = u2;
    assign if_a.branch_taken_EX = br;      assign if_b.branch_taken_EX = br;

    hazard_unit_mc #(.REG_AW(5), .LOAD_STALL(1), .LONG_LAT(LL), .STAT_W(16)) u_a (
        .clk(clk), .rst(rst), .hz(if_a), .stall_count(sc_a));
    hazard_unit_mc #(.REG_AW(5), .LOAD_STALL(3), .LONG_LAT(LL), .STAT_W(4)) u_b (
        .clk(clk), .rst(rst), .hz(if_b), .stall_count(sc_b));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // expected behaviour from remaining stall cycles, then advance the model by one cycle
    task automatic model_check(input int d, input string nm,
                               input logic pc, input logic ifid, input logic idex,
                               input logic cm, input logic fl, input logic exb, input int sc);
        logic e_pc, e_ifid, e_idex, e_cm, e_fl, e_exb, lu;
        e_pc = 1'b1; e_ifid = 1'b1; e_idex = 1'b1; e_cm = 1'b0; e_fl = 1'b0; e_exb = 1'b0;
        lu = mem_read && reg_write && (rd != 5'd0) &&
             ((u1 && (rd == rs1)) || (u2 && (rd == rs2)));
        check_eq({nm, "_count"}, sc, m_cnt[d]);
        if (rst) begin
            m_long[d] = 0; m_load[d] = 0;
        end else if (m_long[d] > 0) begin
            e_pc = 1'b0; e_ifid = 1'b0; e_idex = 1'b0; e_exb = 1'b1;
            m_long[d]--;
        end else if (br) begin
            e_fl = 1'b1; e_cm = 1'b1; m_load[d] = 0;
        end else if (m_load[d] > 0) begin
            e_pc = 1'b0; e_ifid = 1'b0; e_cm = 1'b1; m_load[d]--;
        end else if (lu) begin
            e_pc = 1'b0; e_ifid = 1'b0; e_cm = 1'b1; m_load[d] = ls[d] - 1;
        end else if (long_op) begin
            m_long[d] = LL - 1;
        end
        check_eq({nm, "_PCWrite"}, pc, e_pc);
        check_eq({nm, "_IFIDWrite"}, ifid, e_ifid);
        check_eq({nm, "_IDEXWrite"}, idex, e_idex);
        check_eq({nm, "_control_mux"}, cm, e_cm);
        check_eq({nm, "_flush_IFID"}, fl, e_fl);
        check_eq({nm, "_exmem_bubble"}, exb, e_exb);
        if (rst) m_cnt[d] = 0;
        else if (!e_pc && m_cnt[d] < cap[d]) m_cnt[d]++;
    endtask

    task automatic cyc(input logic r, input logic mr, input logic rw, input logic lo,
                       input int d_rd, input int d_rs1, input int d_rs2,
                       input logic d_u1, input logic d_u2, input logic d_br);
        @(posedge clk);
        #1;
        rst = r; mem_read = mr; reg_write = rw; long_op = lo;
        rd = 5'(d_rd); rs1 = 5'(d_rs1); rs2 = 5'(d_rs2); u1 = d_u1; u2 = d_u2; br = d_br;
        @(negedge clk);
        model_check(0, "A", if_a.PCWrite, if_a.IFIDWrite, if_a.IDEXWrite,
                    if_a.control_mux, if_a.flush_IFID, if_a.exmem_bubble, int'(sc_a));
        model_check(1, "B", if_b.PCWrite, if_b.IFIDWrite, if_b.IDEXWrite,
                    if_b.control_mux, if_b.flush_IFID, if_b.exmem_bubble, int'(sc_b));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; mem_read = 1'b0; reg_write = 1'b0; long_op = 1'b0; br = 1'b0;
        rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; u1 = 1'b0; u2 = 1'b0;
        repeat (2) @(posedge clk);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        check_eq("reset_count_A", 32'(sc_a), 32'd0);
        check_eq("reset_PCWrite_A", 32'(if_a.PCWrite), 32'd1);

        // classic lw x5 / add x?, x5
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 5, 5, 7, 1'b1, 1'b1, 1'b0);
        idle(4);
        check_eq("lu_count_A", 32'(sc_a), 32'd1);
        check_eq("lu_count_B", 32'(sc_b), 32'd3);
        // load to x0 and unused rs2 never stall
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 5, 6, 5, 1'b1, 1'b0, 1'b0);
        idle(1);
        // long op with redirects during the busy window
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        idle(2);
        // branch in the first load-wait cycle aborts the remaining stall
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 9, 9, 0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        idle(3);
        // reset in the middle of a long op
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        idle(1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        idle(1);
        check_eq("rst_mid_long_count_B", 32'(sc_b), 32'd0);
        check_eq("rst_mid_long_IDEXWrite_B", 32'(if_b.IDEXWrite), 32'd1);
        // back-to-back long ops drive the 4-bit counter into saturation
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 2, 0, 0, 1'b0, 1'b0, 1'b0);
        idle(2);
        check_eq("saturate_B", 32'(sc_b), 32'd15);

        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 8),
                ($urandom_range(0, 9) == 0),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Parametrised, stateful hazard unit for the 5-stage RISC-V pipeline. It replaces the single-cycle load-use detector.
- Handles four cases:
  - load-use stalls of configurable length (multi-cycle data memory);
  - multi-cycle EX operations (mul/div) that freeze the front end;
  - taken-branch flush of IF/ID;
  - a saturating stall-cycle performance counter.
- Sits in ID, driving PC, IF/ID and ID/EX write enables and the control bubble mux.

Parameters:
- REG_AW, 5, register address width.
- LOAD_STALL, 1, bubble cycles inserted per load-use hazard (>=1).
- LONG_LAT, 4, EX occupancy in cycles of a long op (>=2).
- STAT_W, 16, width of the stall counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous reset, active-high.
- MemRead_IDEX  in  1  instruction in ID/EX is a load.
- RegWrite_IDEX  in  1  instruction in ID/EX writes rd.
- long_op_IDEX  in  1  instruction in ID/EX is a multi-cycle EX op.
- rd_IDEX  in  REG_AW  destination register of the ID/EX instruction.
- rs1_IFID  in  REG_AW  source register 1 of the decoding instruction.
- rs2_IFID  in  REG_AW  source register 2 of the decoding instruction.
- rs1_used_IFID  in  1  decoding instruction reads rs1.
- rs2_used_IFID  in  1  decoding instruction reads rs2.
- branch_taken_EX  in  1  redirect from EX this cycle.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID register enable.
- IDEXWrite  out  1  ID/EX register enable; 0 holds the long op in EX.
- control_mux  out  1  1 = zero control bits into ID/EX (bubble).
- flush_IFID  out  1  1 = clear IF/ID to NOP.
- exmem_bubble  out  1  1 = insert bubble into EX/MEM while EX is busy.
- stall_count  out  STAT_W  saturating count of stalled cycles.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- State machine has three states: IDLE, LOAD_WAIT, LONG_BUSY. A counter cnt is ceil(log2(max(LOAD_STALL,LONG_LAT)))+1 bits wide.
- Reset: state=IDLE, cnt=0, stall_count=0. While rst is high, outputs are forced to PCWrite=1, IFIDWrite=1, IDEXWrite=1, control_mux=0, flush_IFID=0, exmem_bubble=0.
- Reset mid-operation: an asserted rst aborts any stall within the same edge; the next cycle is IDLE.
- Hazard term lu = MemRead_IDEX & RegWrite_IDEX & rd_IDEX!=0 & ((rs1_used_IFID & rd_IDEX==rs1_IFID) | (rs2_used_IFID & rd_IDEX==rs2_IFID)).
- Outputs are combinational from state and inputs. Priority, highest first:
  1. LONG_BUSY: PCWrite=0, IFIDWrite=0, IDEXWrite=0, exmem_bubble=1, control_mux=0. cnt decrements each cycle. When cnt==1, next state is IDLE, and that cycle still stalls. branch_taken_EX is ignored, since EX holds a long op.
  2. branch_taken_EX (IDLE or LOAD_WAIT):
     - flush_IFID=1, control_mux=1, PCWrite=1, IFIDWrite=1.
     - Next state is IDLE and cnt=0, which aborts any LOAD_WAIT because the dependent instruction is wrong-path.
  3. LOAD_WAIT: PCWrite=0, IFIDWrite=0, control_mux=1. cnt decrements; when cnt==1, next state is IDLE.
  4. IDLE with lu:
     - PCWrite=0, IFIDWrite=0, control_mux=1.
     - If LOAD_STALL>1, next state is LOAD_WAIT with cnt=LOAD_STALL-1. Otherwise stay IDLE; the single-cycle stall matches classic behaviour.
  5. IDLE with long_op_IDEX:
     - Next state is LONG_BUSY with cnt=LONG_LAT-1. The entry cycle itself does not stall; the op's first EX cycle is counted.
     - The op occupies EX for exactly LONG_LAT cycles total.
     - A simultaneous lu is impossible (a long op is not a load); if both are asserted, lu takes priority and long_op is sampled again next cycle.
  6. Otherwise, pass-through values apply: PCWrite=1, IFIDWrite=1, IDEXWrite=1, control_mux=0, flush_IFID=0, exmem_bubble=0.
- IDEXWrite is 0 only in LONG_BUSY. flush_IFID is 1 only under rule 2.
- Total stall lengths:
  - A load-use hazard yields exactly LOAD_STALL consecutive cycles with control_mux=1.
  - A long op yields LONG_LAT-1 front-end-frozen cycles.
- stall_count increments by 1 on every cycle where PCWrite==0 and rst==0. It saturates at all-ones and never wraps.
- rd_IDEX==0 never causes a stall, even for a load to x0.

Decomposition:
- Shared package hazard_pkg holds:
  - state enum (IDLE, LOAD_WAIT, LONG_BUSY);
  - REG_AW default;
  - localparam for the x0 address.
- One natural sub-module: hazard_stall_counter, a loadable down-counter with a "last" flag. It is reused for both LOAD_WAIT and LONG_BUSY.
- Hazard compare logic stays inline.

Test Plan:
- Classic load-use, LOAD_STALL=1: lw x5 in IDEX, add uses rs1=x5 -> one cycle PCWrite=0, IFIDWrite=0, control_mux=1; next cycle pass-through; stall_count=1.
- Slow memory, LOAD_STALL=3: same lw/add pair -> exactly 3 consecutive cycles with control_mux=1, passing through LOAD_WAIT with cnt 2 then 1; stall_count=3.
- No false stalls:
  - lw x0 with rs1=x0 -> no stall.
  - lw x5 with rs2=x5 but rs2_used=0 -> no stall.
- Long op, LONG_LAT=4: long_op_IDEX pulse -> following 3 cycles PCWrite=0, IDEXWrite=0, exmem_bubble=1; 4th cycle pass-through; branch_taken_EX during these cycles has no effect.
- Branch aborts load wait, LOAD_STALL=3: branch_taken_EX=1 in the first LOAD_WAIT cycle -> flush_IFID=1, control_mux=1, PCWrite=1; next cycle IDLE, no further stall.
- Reset and saturation:
  - rst=1 mid-LONG_BUSY -> next cycle IDLE, stall_count=0, outputs at reset values.
  - With STAT_W=4 and 20 stalled cycles -> stall_count holds 15.
